// File: rtl/sensor_frame_pkg.sv
// Shared definitions for the multi-sensor frame aggregator.
//   HEADER_DEFAULT  : first byte of every frame unless overridden
//   STAT_*          : bit positions inside a channel status byte
//   BYTES_PER_CHAN  : status byte + 14 data bytes per channel
//   sensor_sample_t : one quaternion + gyro sample, quat_w in the MSBs so the
//                     packed struct read MSB-first is the on-wire byte order
//   frame_state_t   : frame streaming FSM states
package sensor_frame_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  localparam int STAT_INIT  = 0;
  localparam int STAT_ERR   = 1;
  localparam int STAT_FRESH = 2;
  localparam int STAT_STALE = 3;

  localparam int BYTES_PER_CHAN = 15;
  localparam int DATA_BYTES     = BYTES_PER_CHAN - 1;

  typedef struct packed {
    logic signed [15:0] quat_w;
    logic signed [15:0] quat_x;
    logic signed [15:0] quat_y;
    logic signed [15:0] quat_z;
    logic signed [15:0] gyro_x;
    logic signed [15:0] gyro_y;
    logic signed [15:0] gyro_z;
  } sensor_sample_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_SEQ   = 3'd2,
    ST_CHAN  = 3'd3,
    ST_CKSUM = 3'd4
  } frame_state_t;

endpackage

// File: rtl/sensor_frame_aggregator_tracker.sv
// Per-channel tracker: holds the latest sample, a fresh flag and a staleness
// counter for one sensor channel.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_sample_valid   : one-cycle pulse, i_sample_data is a new sample
//   i_sample_data    : incoming sample
//   i_clear_fresh    : snapshot taken this edge; a same-edge sample wins
//   o_latest         : most recent sample
//   o_fresh          : a sample arrived since the last snapshot
//   o_stale          : no sample for STALE_CYCLES cycles (or none since reset)
module sensor_channel_tracker
  import sensor_frame_pkg::*;
#(
  parameter int STALE_CYCLES = 2400000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_sample_valid,
  input  sensor_sample_t i_sample_data,
  input  logic           i_clear_fresh,
  output sensor_sample_t o_latest,
  output logic           o_fresh,
  output logic           o_stale
);

  localparam int CW = $clog2(STALE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STALE_CYCLES);

  sensor_sample_t r_latest;
  logic           r_fresh;
  logic [CW-1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_latest <= '0;
      r_fresh  <= 1'b0;
      r_cnt    <= CNT_MAX;  // reads as stale until the first sample
    end else if (i_sample_valid) begin
      r_latest <= i_sample_data;
      r_fresh  <= 1'b1;
      r_cnt    <= '0;
    end else begin
      if (i_clear_fresh) r_fresh <= 1'b0;
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_latest = r_latest;
  assign o_fresh  = r_fresh;
  assign o_stale  = (r_cnt == CNT_MAX);

endmodule

// File: rtl/sensor_frame_aggregator.sv
// Multi-sensor frame aggregator. Tracks latest sample and status per channel,
// snapshots all channels atomically on frame_req and streams one checksummed
// frame: HEADER, seq, {status, 14 data bytes} per channel, checksum.
//   clk, rst      : clock, synchronous active-high reset
//   sample_valid  : per-channel new-sample pulse
//   sample_quat   : per channel {w,x,y,z}, channel 0 in LSBs
//   sample_gyro   : per channel {x,y,z}, channel 0 in LSBs
//   sensor_init   : per-channel initialized level
//   sensor_err    : per-channel error level
//   frame_req     : frame request pulse (ignored and counted while busy)
//   byte_data/byte_valid/byte_ready : byte stream out
//   frame_active  : frame in progress
//   frame_done    : pulse the cycle after the checksum byte is accepted
//   req_dropped   : saturating count of ignored requests
// Handshake: a byte transfers on any edge where byte_valid and byte_ready are
// both high; byte_valid and byte_data hold until that edge, and the next byte
// is presented the following cycle.
module sensor_frame_aggregator
  import sensor_frame_pkg::*;
#(
  parameter int          N_SENSORS    = 2,
  parameter int          STALE_CYCLES = 2400000,
  parameter logic [7:0]  HEADER       = HEADER_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SENSORS-1:0]    sample_valid,
  input  logic [64*N_SENSORS-1:0] sample_quat,
  input  logic [48*N_SENSORS-1:0] sample_gyro,
  input  logic [N_SENSORS-1:0]    sensor_init,
  input  logic [N_SENSORS-1:0]    sensor_err,
  input  logic                    frame_req,
  output logic [7:0]              byte_data,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    frame_active,
  output logic                    frame_done,
  output logic [7:0]              req_dropped
);

  localparam int CHW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam logic [CHW-1:0] LAST_CHAN = CHW'(N_SENSORS - 1);
  localparam logic [3:0]     LAST_BYTE = 4'(BYTES_PER_CHAN - 1);

  frame_state_t   r_state, w_next_state;
  logic [CHW-1:0] r_chan;
  logic [3:0]     r_byte;
  logic [7:0]     r_seq, r_cksum, r_dropped;
  logic           r_frame_done;

  sensor_sample_t             w_sample [N_SENSORS];
  sensor_sample_t             w_latest [N_SENSORS];
  logic [N_SENSORS-1:0]       w_fresh, w_stale;
  sensor_sample_t             r_snap [N_SENSORS];
  logic [7:0]                 r_snap_status [N_SENSORS];

  logic           w_busy, w_accept, w_hs;
  sensor_sample_t w_cur_sample;
  logic [7:0]     w_byte;

  // The frame_done cycle still counts as busy so a request there is dropped.
  assign w_busy   = (r_state != ST_IDLE) || r_frame_done;
  assign w_accept = frame_req && !w_busy;
  assign w_hs     = byte_valid && byte_ready;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_chan
    assign w_sample[g] = sensor_sample_t'({sample_quat[g*64 +: 64], sample_gyro[g*48 +: 48]});

    sensor_channel_tracker #(.STALE_CYCLES(STALE_CYCLES)) u_tracker (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_sample_valid (sample_valid[g]),
      .i_sample_data  (w_sample[g]),
      .i_clear_fresh  (w_accept),
      .o_latest       (w_latest[g]),
      .o_fresh        (w_fresh[g]),
      .o_stale        (w_stale[g])
    );
  end

  // Snapshot reads the trackers' registered values, so a sample on the
  // acceptance edge lands in latest only and stays fresh for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SENSORS; i++) begin
        r_snap[i]        <= '0;
        r_snap_status[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < N_SENSORS; i++) begin
        r_snap[i]                    <= w_latest[i];
        r_snap_status[i][7:4]        <= 4'(i);
        r_snap_status[i][STAT_STALE] <= w_stale[i];
        r_snap_status[i][STAT_FRESH] <= w_fresh[i];
        r_snap_status[i][STAT_ERR]   <= sensor_err[i];
        r_snap_status[i][STAT_INIT]  <= sensor_init[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_HDR;
      ST_HDR:   if (w_hs) w_next_state = ST_SEQ;
      ST_SEQ:   if (w_hs) w_next_state = ST_CHAN;
      ST_CHAN:  if (w_hs && r_byte == LAST_BYTE && r_chan == LAST_CHAN) w_next_state = ST_CKSUM;
      ST_CKSUM: if (w_hs) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output byte is a pure function of registers that only move on a
  // handshake, which keeps it stable while the consumer stalls.
  always_comb begin
    w_cur_sample = r_snap[r_chan];
    w_byte       = '0;
    case (r_state)
      ST_HDR:   w_byte = HEADER;
      ST_SEQ:   w_byte = r_seq;
      ST_CHAN: begin
        if (r_byte == 4'd0) begin
          w_byte = r_snap_status[r_chan];
        end else begin
          for (int k = 0; k < DATA_BYTES; k++) begin
            if (r_byte == 4'(k + 1)) w_byte = w_cur_sample[8*(DATA_BYTES-1-k) +: 8];
          end
        end
      end
      ST_CKSUM: w_byte = r_cksum;
      default:  w_byte = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chan       <= '0;
      r_byte       <= '0;
      r_seq        <= '0;
      r_cksum      <= '0;
      r_dropped    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == ST_CKSUM) && w_hs;
      if (frame_req && w_busy && r_dropped != 8'hFF) r_dropped <= r_dropped + 1'b1;
      if (w_accept) begin
        r_chan  <= '0;
        r_byte  <= '0;
        r_cksum <= '0;
      end else if (w_hs) begin
        if (r_state != ST_CKSUM) r_cksum <= r_cksum + w_byte;
        if (r_state == ST_CHAN) begin
          if (r_byte == LAST_BYTE) begin
            r_byte <= '0;
            r_chan <= (r_chan == LAST_CHAN) ? '0 : r_chan + 1'b1;
          end else begin
            r_byte <= r_byte + 1'b1;
          end
        end
        if (r_state == ST_CKSUM) r_seq <= r_seq + 1'b1;
      end
    end
  end

  assign byte_data    = w_byte;
  assign byte_valid   = (r_state != ST_IDLE);
  assign frame_active = (r_state != ST_IDLE);
  assign frame_done   = r_frame_done;
  assign req_dropped  = r_dropped;

endmodule
